// File: rtl/aes_sched_pkg.sv
// Shared types and widths for the AES decrypt scheduler.
package aes_sched_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int COUNT_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_RESP   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/aes_decrypt_sched_if.sv
// Request/response bus between the requesters (master) and the scheduler (slave).
interface aes_decrypt_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) ();
    import aes_sched_pkg::*;

    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ*AES_BLOCK_W-1:0] req_data;
    logic [NREQ*AES_BLOCK_W-1:0] req_key;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [IDW-1:0]              rsp_id;
    logic [AES_BLOCK_W-1:0]      rsp_data;
    logic                        rsp_err;

    modport master (
        output req_valid, req_data, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_data, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

endinterface

// File: rtl/aes_rr_pick.sv
// Round-robin picker: first valid requester at or above ptr, wrapping at NREQ.
module aes_rr_pick
    import aes_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [IDW:0] pos_s;
    logic         found_s;
    logic         hit_s;

    // scan NREQ slots starting at ptr; the first hit wins
    always_comb begin
        pos_s   = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos_s   = {1'b0, ptr} + (IDW+1)'(k);
            pos_s   = (pos_s >= (IDW+1)'(NREQ)) ? pos_s - (IDW+1)'(NREQ) : pos_s;
            hit_s   = valid[pos_s[IDW-1:0]];
            idx     = (!found_s && hit_s) ? pos_s[IDW-1:0] : idx;
            found_s = found_s | hit_s;
        end
        grant      = '0;
        grant[idx] = found_s;
    end

    assign any = |valid;

endmodule

// File: rtl/aes_decrypt_sched.sv
// Round-robin scheduler sharing one AES-128 decrypt core between NREQ requesters.
// Optional core watchdog is enabled by defining AES_SCHED_TIMEOUT_EN.
module aes_decrypt_sched
    import aes_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = $clog2(NREQ),
    parameter int TIMEOUT = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    aes_decrypt_sched_if.slave     bus,
    output logic                   core_start,
    output logic [AES_BLOCK_W-1:0] core_in,
    output logic [AES_BLOCK_W-1:0] core_key,
    input  logic                   core_finish,
    input  logic [AES_BLOCK_W-1:0] core_out,
    output logic                   busy,
    output logic [COUNT_W-1:0]     op_count
);

    sched_state_t           state_r;
    logic [IDW-1:0]         ptr_r;
    logic [IDW-1:0]         id_r;
    logic                   core_start_r;
    logic                   busy_r;
    logic                   rsp_valid_r;
    logic [AES_BLOCK_W-1:0] core_in_r;
    logic [AES_BLOCK_W-1:0] core_key_r;
    logic [AES_BLOCK_W-1:0] rsp_data_r;
    logic [COUNT_W-1:0]     op_count_r;

    logic [NREQ-1:0]        pick_grant_s;
    logic [IDW-1:0]         pick_idx_s;
    logic                   pick_any_s;

`ifdef AES_SCHED_TIMEOUT_EN
    logic [15:0]            wd_cnt_r;
    logic                   rsp_err_r;
`endif

    aes_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .valid (bus.req_valid),
        .ptr   (ptr_r),
        .grant (pick_grant_s),
        .idx   (pick_idx_s),
        .any   (pick_any_s)
    );

    // grant is only offered while idle; the picker already returns zero when nothing is valid
    assign bus.req_ready = (!rst && state_r == ST_IDLE) ? pick_grant_s : '0;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = id_r;
    assign bus.rsp_data  = rsp_data_r;
    assign core_start    = core_start_r;
    assign core_in       = core_in_r;
    assign core_key      = core_key_r;
    assign busy          = busy_r;
    assign op_count      = op_count_r;

`ifdef AES_SCHED_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_r;
`else
    assign bus.rsp_err   = 1'b0;
    // without the watchdog TIMEOUT has no effect beyond this range guard
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    // scheduler FSM: accept, launch core, wait for result, hand result back
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            ptr_r        <= '0;
            id_r         <= '0;
            core_start_r <= 1'b0;
            busy_r       <= 1'b0;
            rsp_valid_r  <= 1'b0;
            core_in_r    <= '0;
            core_key_r   <= '0;
            rsp_data_r   <= '0;
            op_count_r   <= '0;
`ifdef AES_SCHED_TIMEOUT_EN
            wd_cnt_r     <= 16'd0;
            rsp_err_r    <= 1'b0;
`endif
        end else begin
            core_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_any_s) begin
                        id_r         <= pick_idx_s;
                        core_in_r    <= bus.req_data[AES_BLOCK_W*pick_idx_s +: AES_BLOCK_W];
                        core_key_r   <= bus.req_key[AES_BLOCK_W*pick_idx_s +: AES_BLOCK_W];
                        core_start_r <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
`ifdef AES_SCHED_TIMEOUT_EN
                    wd_cnt_r <= 16'd0;
`endif
                    state_r  <= ST_BUSY;
                end
                ST_BUSY: begin
                    // a finish in the same cycle as watchdog expiry takes priority
                    if (core_finish) begin
                        rsp_data_r  <= core_out;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
`ifdef AES_SCHED_TIMEOUT_EN
                        rsp_err_r   <= 1'b0;
                    end else if (wd_cnt_r == 16'(TIMEOUT - 1)) begin
                        rsp_data_r  <= '0;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        wd_cnt_r    <= wd_cnt_r + 16'd1;
`endif
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        ptr_r       <= (id_r == IDW'(NREQ - 1)) ? '0 : id_r + IDW'(1);
                        op_count_r  <= op_count_r + 32'd1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_sched.sv
// Directed bench for aes_decrypt_sched with a fixed-latency core model.
module tb_aes_decrypt_sched;
    import aes_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         core_start;
    logic         core_finish;
    logic [127:0] core_in;
    logic [127:0] core_key;
    logic [127:0] core_out;
    logic         busy;
    logic [31:0]  op_count;

    logic         model_finish = 1'b0;
    logic [127:0] model_out    = 128'd0;
    logic         spur         = 1'b0;
    logic         core_dead    = 1'b0;
    int           lat          = 11;
    int           cnt          = 0;
    int           start_cnt    = 0;
    logic         err_seen     = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc   = 0;
    int s0    = 0;
    logic [127:0] rr_data [4];
    logic [127:0] rr_key  [4];
    logic [127:0] exp_data;
    logic         any_act;

    aes_decrypt_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    assign core_finish = model_finish | spur;
    assign core_out    = model_out;

    aes_decrypt_sched #(
        .NREQ    (NREQ),
        .IDW     (IDW),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .core_start  (core_start),
        .core_in     (core_in),
        .core_key    (core_key),
        .core_finish (core_finish),
        .core_out    (core_out),
        .busy        (busy),
        .op_count    (op_count)
    );

    always #5 clk = ~clk;

    // core model: finish lat cycles after the start cycle
    always @(posedge clk) begin
        model_finish <= 1'b0;
        if (cnt == 1 && !core_dead) begin
            model_finish <= 1'b1;
            model_out    <= (core_in == FIPS_CT && core_key == FIPS_KEY) ? FIPS_PT : (core_in ^ core_key);
        end
        if (core_start) cnt <= lat - 1;
        else if (cnt > 0) cnt <= cnt - 1;
        if (core_start) start_cnt <= start_cnt + 1;
        if (bus.rsp_err) err_seen <= 1'b1;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_rsp(input int max);
        int n;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < max) begin
            step();
            n++;
        end
        check_eq("rsp_wait", {127'd0, bus.rsp_valid}, 128'd1);
    endtask

    task automatic set_req(input int i, input logic [127:0] d, input logic [127:0] k);
        bus.req_data[128*i +: 128] = d;
        bus.req_key[128*i +: 128]  = k;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 1'b0;
        spur          = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            rr_data[i] = {4{32'ha5a5_0000 + 32'(i)}};
            rr_key[i]  = {4{32'h0f0f_1000 + 32'(i * 3)}};
        end
        bus.req_data  = '0;
        bus.req_key   = '0;
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 1'b0;

        // reset state
        do_reset();
        check_eq("rst_busy",      128'(busy),          128'd0);
        check_eq("rst_rsp_valid", 128'(bus.rsp_valid), 128'd0);
        check_eq("rst_req_ready", 128'(bus.req_ready), 128'd0);
        check_eq("rst_start",     128'(core_start),    128'd0);
        check_eq("rst_core_in",   core_in,             128'd0);
        check_eq("rst_core_key",  core_key,            128'd0);
        check_eq("rst_op_count",  128'(op_count),      128'd0);
        check_eq("rst_rsp_data",  bus.rsp_data,        128'd0);
        check_eq("rst_rsp_err",   128'(bus.rsp_err),   128'd0);

        // FIPS-197 vector from requester 2, latency 11
        bus.rsp_ready = 1'b1;
        set_req(2, FIPS_CT, FIPS_KEY);
        bus.req_valid = 4'b0100;
        #1;
        check_eq("fips_ready", 128'(bus.req_ready), 128'h4);
        acc = cyc;
        step();
        bus.req_valid = 4'b0000;
        check_eq("fips_start",   128'(core_start), 128'd1);
        check_eq("fips_core_in", core_in,          FIPS_CT);
        check_eq("fips_core_key", core_key,        FIPS_KEY);
        wait_rsp(40);
        check_eq("fips_latency", 128'(cyc - acc),   128'd13);
        check_eq("fips_id",      128'(bus.rsp_id),  128'd2);
        check_eq("fips_data",    bus.rsp_data,      FIPS_PT);
        check_eq("fips_err",     128'(bus.rsp_err), 128'd0);
        step();
        check_eq("fips_idle",    128'(busy),        128'd0);
        check_eq("fips_opcount", 128'(op_count),    128'd1);
        check_eq("fips_ptr",     128'(dut.ptr_r),   128'd3);

        // all four requesters pending for 8 operations
        do_reset();
        lat = 4;
        for (int i = 0; i < 4; i++) set_req(i, rr_data[i], rr_key[i]);
        bus.rsp_ready = 1'b1;
        s0 = start_cnt;
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_rsp(40);
            check_eq("rr_id",   128'(bus.rsp_id), 128'(k % 4));
            check_eq("rr_data", bus.rsp_data,     rr_data[k % 4] ^ rr_key[k % 4]);
            if (k == 7) bus.req_valid = 4'b0000;
            step();
        end
        step();
        step();
        check_eq("rr_starts",   128'(start_cnt - s0), 128'd8);
        check_eq("rr_op_count", 128'(op_count),       128'd8);

        // response stalled for 20 cycles
        do_reset();
        bus.req_valid = 4'b0010;
        step();
        bus.req_valid = 4'b1000;
        wait_rsp(40);
        exp_data = rr_data[1] ^ rr_key[1];
        s0 = start_cnt;
        for (int k = 0; k < 20; k++) begin
            step();
            check_eq("stall_valid", 128'(bus.rsp_valid), 128'd1);
            check_eq("stall_id",    128'(bus.rsp_id),    128'd1);
            check_eq("stall_data",  bus.rsp_data,        exp_data);
            check_eq("stall_ready", 128'(bus.req_ready), 128'd0);
        end
        check_eq("stall_starts", 128'(start_cnt - s0), 128'd0);
        bus.rsp_ready = 1'b1;
        step();
        check_eq("release_busy",  128'(busy),          128'd0);
        check_eq("release_ready", 128'(bus.req_ready), 128'h8);
        check_eq("release_count", 128'(op_count),      128'd1);
        step();
        bus.req_valid = 4'b0000;
        check_eq("release_start", 128'(core_start), 128'd1);
        check_eq("release_in",    core_in,          rr_data[3]);
        wait_rsp(40);
        check_eq("release_id", 128'(bus.rsp_id), 128'd3);
        step();

        // spurious core_finish in IDLE and LAUNCH
        do_reset();
        lat = 11;
        bus.rsp_ready = 1'b1;
        spur = 1'b1;
        step();
        spur = 1'b0;
        check_eq("spur_idle_busy",  128'(busy),          128'd0);
        check_eq("spur_idle_valid", 128'(bus.rsp_valid), 128'd0);
        step();
        check_eq("spur_idle_valid2", 128'(bus.rsp_valid), 128'd0);
        check_eq("spur_idle_count",  128'(op_count),      128'd0);
        bus.req_valid = 4'b0001;
        acc = cyc;
        step();
        bus.req_valid = 4'b0000;
        spur = 1'b1;
        check_eq("spur_launch_start", 128'(core_start), 128'd1);
        step();
        spur = 1'b0;
        check_eq("spur_launch_valid", 128'(bus.rsp_valid), 128'd0);
        check_eq("spur_launch_busy",  128'(busy),          128'd1);
        wait_rsp(40);
        check_eq("spur_latency", 128'(cyc - acc), 128'd13);
        check_eq("spur_data",    bus.rsp_data,    rr_data[0] ^ rr_key[0]);
        step();
        check_eq("spur_ptr", 128'(dut.ptr_r), 128'd1);

        // reset while BUSY, then a late core_finish
        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = 4'b0000;
        step();
        step();
        check_eq("busy_before_rst", 128'(busy), 128'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rst_busy",     128'(busy),          128'd0);
        check_eq("mid_rst_valid",    128'(bus.rsp_valid), 128'd0);
        check_eq("mid_rst_core_in",  core_in,             128'd0);
        check_eq("mid_rst_core_key", core_key,            128'd0);
        check_eq("mid_rst_count",    128'(op_count),      128'd0);
        check_eq("mid_rst_ptr",      128'(dut.ptr_r),     128'd0);
        check_eq("mid_rst_state",    128'(dut.state_r),   128'(ST_IDLE));
        any_act = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            any_act = any_act | bus.rsp_valid | busy;
        end
        check_eq("late_finish_ignored", 128'(any_act), 128'd0);

        // core never finishes
        core_dead = 1'b1;
        bus.req_valid = 4'b0001;
        acc = cyc;
        step();
        bus.req_valid = 4'b0000;
`ifdef AES_SCHED_TIMEOUT_EN
        wait_rsp(60);
        check_eq("to_latency", 128'(cyc - acc),   128'd18);
        check_eq("to_err",     128'(bus.rsp_err), 128'd1);
        check_eq("to_data",    bus.rsp_data,      128'd0);
        check_eq("to_id",      128'(bus.rsp_id),  128'd0);
        step();
        check_eq("to_count",   128'(op_count),    128'd1);
        check_eq("to_idle",    128'(busy),        128'd0);
`else
        for (int k = 0; k < 40; k++) step();
        check_eq("hang_busy",  128'(busy),          128'd1);
        check_eq("hang_valid", 128'(bus.rsp_valid), 128'd0);
        check_eq("err_never",  128'(err_seen),      128'd0);
`endif
        core_dead = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
